// File: rtl/mole_hit_judge_pkg.sv
// Shared definitions for the whack-a-mole hit judge: channel state encoding
// and the default keycode map (channel 0 = key "0" ... channel 9 = key "1").
package mole_hit_judge_pkg;

  typedef enum logic [1:0] {
    CH_IDLE    = 2'd0,
    CH_UP      = 2'd1,
    CH_WHACKED = 2'd2
  } chan_state_t;

  localparam int DEF_N  = 10;
  localparam int DEF_CW = 8;

  localparam logic [9*DEF_N-1:0] DEF_KEYCODES = {
    9'h016, 9'h01E, 9'h026, 9'h025, 9'h02E,
    9'h036, 9'h03D, 9'h03E, 9'h046, 9'h045
  };

endpackage

// File: rtl/mole_chan_fsm.sv
// One mole channel: arms when lit, accepts a single hit per appearance and
// reports an escape when the mole goes dark without being hit.
//   state      | meaning
//   CH_IDLE    | mole dark (or just reset), any matching press is a miss
//   CH_UP      | mole lit and not yet hit, matching press is a hit
//   CH_WHACKED | mole already hit this appearance, further presses miss
module mole_chan_fsm
  import mole_hit_judge_pkg::*;
(
  input  logic clk,
  input  logic rst,
  input  logic clear,
  input  logic mole_on,
  input  logic evt,
  input  logic match,
  output logic hit,
  output logic miss,
  output logic escape
);

  chan_state_t state, state_nxt;
  logic        press;

  assign press = evt & match;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst)       state <= CH_IDLE;
    else if (clear) state <= CH_IDLE;
    else            state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    hit       = 1'b0;
    miss      = 1'b0;
    escape    = 1'b0;
    case (state)
      CH_IDLE: begin
        miss = press;
        if (mole_on) state_nxt = CH_UP;
      end
      CH_UP: begin
        // Mole going dark beats a simultaneous press: escape plus miss.
        if (!mole_on) begin
          escape    = 1'b1;
          miss      = press;
          state_nxt = CH_IDLE;
        end else if (press) begin
          hit       = 1'b1;
          state_nxt = CH_WHACKED;
        end
      end
      CH_WHACKED: begin
        miss = press;
        if (!mole_on) state_nxt = CH_IDLE;
      end
      default: state_nxt = CH_IDLE;
    endcase
  end

endmodule

// File: rtl/mole_hit_judge.sv
// Hit judge: turns fresh key presses into hit/miss events across N mole
// channels and keeps saturating score counters and streaks.
module mole_hit_judge
  import mole_hit_judge_pkg::*;
#(
  parameter int               N        = DEF_N,
  parameter logic [9*N-1:0]   KEYCODES = DEF_KEYCODES,
  parameter int               CW       = DEF_CW
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          clear,
  input  logic [N-1:0]  mole_on,
  input  logic [8:0]    last_change,
  input  logic [511:0]  key_down,
  output logic          hit_pulse,
  output logic [N-1:0]  hit_vec,
  output logic          miss_pulse,
  output logic          escape_pulse,
  output logic [CW-1:0] hit_count,
  output logic [CW-1:0] miss_count,
  output logic [CW-1:0] escape_count,
  output logic [CW-1:0] streak,
  output logic [CW-1:0] best_streak
);

  localparam int EW = $clog2(N + 1);

  logic [8:0]    prev_code;
  logic          prev_held;
  logic          held_now;
  logic          evt;
  logic [N-1:0]  match;
  logic [N-1:0]  hit;
  logic [N-1:0]  miss;
  logic [N-1:0]  esc;
  logic [EW-1:0] esc_cnt;
  logic          hit_any, miss_any, esc_any;
  logic [CW-1:0] streak_nxt, best_nxt;

  function automatic logic [CW-1:0] sat_add(input logic [CW-1:0] a, input logic [EW-1:0] b);
    logic [CW+EW-1:0] s;
    s = {{EW{1'b0}}, a} + {{CW{1'b0}}, b};
    if (s > {{EW{1'b0}}, {CW{1'b1}}}) sat_add = '1;
    else                               sat_add = s[CW-1:0];
  endfunction

  // A press is fresh when the key is down now and was not already the held key.
  assign held_now = key_down[last_change];
  assign evt      = held_now & (~prev_held | (prev_code != last_change)) & ~clear;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      prev_code <= '0;
      prev_held <= 1'b0;
    end else begin
      prev_code <= last_change;
      prev_held <= held_now;
    end
  end

  for (genvar i = 0; i < N; i++) begin : g_chan
    assign match[i] = (last_change == KEYCODES[9*i +: 9]);

    mole_chan_fsm u_fsm (
      .clk     (clk),
      .rst     (rst),
      .clear   (clear),
      .mole_on (mole_on[i]),
      .evt     (evt),
      .match   (match[i]),
      .hit     (hit[i]),
      .miss    (miss[i]),
      .escape  (esc[i])
    );
  end

  always_comb begin
    esc_cnt = '0;
    for (int i = 0; i < N; i++) esc_cnt = esc_cnt + EW'(esc[i]);
  end

  assign hit_any  = |hit;
  assign miss_any = |miss;
  assign esc_any  = |esc;

  // Hit increments first, then any miss/escape in the same cycle zeroes it.
  always_comb begin
    streak_nxt = hit_any ? sat_add(streak, EW'(1)) : streak;
    if (miss_any || esc_any) streak_nxt = '0;
    best_nxt = (streak_nxt > best_streak) ? streak_nxt : best_streak;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      hit_pulse    <= 1'b0;
      hit_vec      <= '0;
      miss_pulse   <= 1'b0;
      escape_pulse <= 1'b0;
      hit_count    <= '0;
      miss_count   <= '0;
      escape_count <= '0;
      streak       <= '0;
      best_streak  <= '0;
    end else if (clear) begin
      hit_pulse    <= 1'b0;
      hit_vec      <= '0;
      miss_pulse   <= 1'b0;
      escape_pulse <= 1'b0;
      hit_count    <= '0;
      miss_count   <= '0;
      escape_count <= '0;
      streak       <= '0;
      best_streak  <= '0;
    end else begin
      hit_pulse    <= hit_any;
      hit_vec      <= hit;
      miss_pulse   <= miss_any;
      escape_pulse <= esc_any;
      hit_count    <= hit_any  ? sat_add(hit_count, EW'(1))  : hit_count;
      miss_count   <= miss_any ? sat_add(miss_count, EW'(1)) : miss_count;
      escape_count <= sat_add(escape_count, esc_cnt);
      streak       <= streak_nxt;
      best_streak  <= best_nxt;
    end
  end

endmodule

// File: tb/tb_mole_hit_judge.sv
// Scoreboard bench for mole_hit_judge: a reference model predicts each cycle,
// checked against a CW=8 and a CW=4 instance driven by the same stimulus.
module tb_mole_hit_judge;

  localparam int N = 10;
  localparam logic [9*N-1:0] KC = {
    9'h016, 9'h01E, 9'h026, 9'h025, 9'h02E,
    9'h036, 9'h03D, 9'h03E, 9'h046, 9'h045
  };

  logic          clk = 1'b0;
  logic          rst;
  logic          clear;
  logic [N-1:0]  mole_on;
  logic [8:0]    last_change;
  logic [511:0]  key_down;

  logic          hit_pulse, miss_pulse, escape_pulse;
  logic [N-1:0]  hit_vec;
  logic [7:0]    hit_count, miss_count, escape_count, streak, best_streak;

  logic          hit_pulse4, miss_pulse4, escape_pulse4;
  logic [N-1:0]  hit_vec4;
  logic [3:0]    hit_count4, miss_count4, escape_count4, streak4, best_streak4;

  always #5 clk = ~clk;

  mole_hit_judge dut (
    .clk(clk), .rst(rst), .clear(clear), .mole_on(mole_on),
    .last_change(last_change), .key_down(key_down),
    .hit_pulse(hit_pulse), .hit_vec(hit_vec), .miss_pulse(miss_pulse),
    .escape_pulse(escape_pulse), .hit_count(hit_count), .miss_count(miss_count),
    .escape_count(escape_count), .streak(streak), .best_streak(best_streak)
  );

  mole_hit_judge #(.CW(4)) dut4 (
    .clk(clk), .rst(rst), .clear(clear), .mole_on(mole_on),
    .last_change(last_change), .key_down(key_down),
    .hit_pulse(hit_pulse4), .hit_vec(hit_vec4), .miss_pulse(miss_pulse4),
    .escape_pulse(escape_pulse4), .hit_count(hit_count4), .miss_count(miss_count4),
    .escape_count(escape_count4), .streak(streak4), .best_streak(best_streak4)
  );

  typedef struct {
    logic         hp;
    logic [N-1:0] hv;
    logic         mp;
    logic         ep;
    int           hc, mc, ec, st, bs;
  } exp_t;

  exp_t sb[$];

  int n_tests = 0;
  int n_fail  = 0;

  // reference model state (unsaturated counts; saturation applied per instance)
  int         m_st[N];
  logic [8:0] m_prev_code;
  logic       m_prev_held;
  int         m_hc, m_mc, m_ec, m_streak, m_best;

  function automatic int satv(input int x, input int mx);
    return (x > mx) ? mx : x;
  endfunction

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    assert (got === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic m_reset();
    for (int k = 0; k < N; k++) m_st[k] = 0;
    m_prev_code = '0;
    m_prev_held = 1'b0;
    m_hc = 0; m_mc = 0; m_ec = 0; m_streak = 0; m_best = 0;
  endtask

  task automatic step();
    exp_t e;
    logic held, evt, ev, h, m;
    int   esc_n;
    held  = key_down[last_change];
    evt   = held && (!m_prev_held || (m_prev_code != last_change));
    m_prev_code = last_change;
    m_prev_held = held;
    e.hp = 1'b0; e.hv = '0; e.mp = 1'b0; e.ep = 1'b0;
    if (clear) begin
      for (int k = 0; k < N; k++) m_st[k] = 0;
      m_hc = 0; m_mc = 0; m_ec = 0; m_streak = 0; m_best = 0;
    end else begin
      h = 1'b0; m = 1'b0; esc_n = 0;
      for (int k = 0; k < N; k++) begin
        ev = evt && (last_change == KC[9*k +: 9]);
        case (m_st[k])
          0: begin
            if (ev) m = 1'b1;
            if (mole_on[k]) m_st[k] = 1;
          end
          1: begin
            if (!mole_on[k]) begin
              esc_n++;
              m_st[k] = 0;
              if (ev) m = 1'b1;
            end else if (ev) begin
              h = 1'b1;
              e.hv[k] = 1'b1;
              m_st[k] = 2;
            end
          end
          default: begin
            if (ev) m = 1'b1;
            if (!mole_on[k]) m_st[k] = 0;
          end
        endcase
      end
      if (h) begin m_hc++; m_streak++; end
      if (m) m_mc++;
      m_ec += esc_n;
      if (m || esc_n > 0) m_streak = 0;
      if (m_streak > m_best) m_best = m_streak;
      e.hp = h; e.mp = m; e.ep = (esc_n > 0);
    end
    e.hc = m_hc; e.mc = m_mc; e.ec = m_ec; e.st = m_streak; e.bs = m_best;
    sb.push_back(e);

    @(posedge clk);
    #1;
    e = sb.pop_front();
    chk("hit_pulse",    hit_pulse,    e.hp);
    chk("hit_vec",      hit_vec,      e.hv);
    chk("miss_pulse",   miss_pulse,   e.mp);
    chk("escape_pulse", escape_pulse, e.ep);
    chk("hit_count",    hit_count,    satv(e.hc, 255));
    chk("miss_count",   miss_count,   satv(e.mc, 255));
    chk("escape_count", escape_count, satv(e.ec, 255));
    chk("streak",       streak,       satv(e.st, 255));
    chk("best_streak",  best_streak,  satv(e.bs, 255));
    chk("cw4_hit_pulse",    hit_pulse4,    e.hp);
    chk("cw4_hit_count",    hit_count4,    satv(e.hc, 15));
    chk("cw4_miss_count",   miss_count4,   satv(e.mc, 15));
    chk("cw4_escape_count", escape_count4, satv(e.ec, 15));
    chk("cw4_streak",       streak4,       satv(e.st, 15));
    chk("cw4_best_streak",  best_streak4,  satv(e.bs, 15));
  endtask

  task automatic press(input int ch);
    logic [8:0] code;
    code = KC[9*ch +: 9];
    key_down[code] = 1'b1;
    last_change    = code;
  endtask

  task automatic press_code(input logic [8:0] code);
    key_down[code] = 1'b1;
    last_change    = code;
  endtask

  task automatic release_all();
    key_down = '0;
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_hit_pulse"},    hit_pulse,    0);
    chk({tag, "_hit_vec"},      hit_vec,      0);
    chk({tag, "_miss_pulse"},   miss_pulse,   0);
    chk({tag, "_escape_pulse"}, escape_pulse, 0);
    chk({tag, "_hit_count"},    hit_count,    0);
    chk({tag, "_miss_count"},   miss_count,   0);
    chk({tag, "_escape_count"}, escape_count, 0);
    chk({tag, "_streak"},       streak,       0);
    chk({tag, "_best_streak"},  best_streak,  0);
    chk({tag, "_cw4_hit_count"}, hit_count4,  0);
    chk({tag, "_cw4_streak"},    streak4,     0);
  endtask

  initial begin
    rst = 1'b0; clear = 1'b0; mole_on = '0; last_change = '0; key_down = '0;
    m_reset();
    #12;
    chk_all_zero("reset");
    @(posedge clk); #1;
    rst = 1'b1;

    // single hit on channel 9 with the key held for 5 cycles
    mole_on[9] = 1'b1;
    step();
    press(9);
    step();
    chk("t1_hit_vec", hit_vec, 10'h200);
    for (int i = 0; i < 4; i++) step();
    chk("t1_hit_count", hit_count, 1);
    chk("t1_streak",    streak,    1);

    // second press on the same lit mole is a miss
    release_all(); step();
    press(9); step();
    chk("t2_miss_pulse",  miss_pulse,  1);
    chk("t2_miss_count",  miss_count,  1);
    chk("t2_streak",      streak,      0);
    chk("t2_best_streak", best_streak, 1);
    release_all(); step();

    // escapes: single, then two channels at once
    mole_on[3] = 1'b1; step(); step();
    mole_on[3] = 1'b0; step();
    chk("t3_escape_pulse", escape_pulse, 1);
    chk("t3_escape_count", escape_count, 1);
    mole_on[3] = 1'b1; mole_on[4] = 1'b1; step();
    mole_on[3] = 1'b0; mole_on[4] = 1'b0; step();
    chk("t3_escape_count2", escape_count, 3);

    // press on a mole in the cycle it goes dark: escape plus miss
    mole_on[0] = 1'b1; step();
    press(0); mole_on[0] = 1'b0; step();
    chk("t4_hit_pulse",    hit_pulse,    0);
    chk("t4_escape_count", escape_count, 4);
    chk("t4_miss_count",   miss_count,   2);
    release_all(); step();

    // 20 consecutive hits on distinct appearances
    mole_on = '0; step();
    for (int i = 0; i < 20; i++) begin
      mole_on[i % N] = 1'b1; step();
      press(i % N); step();
      release_all(); mole_on[i % N] = 1'b0; step();
    end
    chk("t5_cw4_hit_count",   hit_count4,   15);
    chk("t5_cw4_streak",      streak4,      15);
    chk("t5_cw4_best_streak", best_streak4, 15);
    chk("t5_hit_count",       hit_count,    21);
    chk("t5_streak",          streak,       20);

    // unmapped key produces nothing
    press_code(9'h01C); step();
    chk("t6_hit_pulse",  hit_pulse,  0);
    chk("t6_miss_pulse", miss_pulse, 0);
    release_all(); step();

    // build a streak of 5, then reset asynchronously mid-cycle
    press(1); step(); release_all(); step();
    for (int i = 0; i < 5; i++) begin
      mole_on[i] = 1'b1; step();
      press(i); step();
      release_all(); mole_on[i] = 1'b0; step();
    end
    chk("t7_streak", streak, 5);
    mole_on[2] = 1'b1;
    #2;
    rst = 1'b0;
    #1;
    chk_all_zero("async_rst");
    m_reset();
    @(posedge clk); #1;
    rst = 1'b1;
    step();
    press(2); step();
    chk("t7_rearm_hit",   hit_pulse, 1);
    chk("t7_rearm_count", hit_count, 1);
    release_all(); mole_on[2] = 1'b0; step();

    // clear with a simultaneous fresh press drops the press
    mole_on[5] = 1'b1; step();
    clear = 1'b1; press(5); step();
    chk("t8_clear_hit_pulse", hit_pulse, 0);
    chk("t8_clear_hit_count", hit_count, 0);
    clear = 1'b0; step();
    chk("t8_held_no_hit", hit_pulse, 0);
    release_all(); step();
    press(5); step();
    chk("t8_repress_hit", hit_pulse, 1);
    release_all(); mole_on = '0; step();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/mole_hit_judge.md
Name: mole_hit_judge

Overview:
- Parametrised hit judge for the whack-a-mole game; generalises the single-bit hit detector to N mole channels with per-channel keycodes.
- Turns each fresh key press into exactly one hit or miss, allows one hit per mole appearance, and flags moles that escape unhit.
- Keeps saturating hit/miss/escape counters plus a current and best streak.
- Sits between the keyboard decoder (last_change/key_down) and the mole LED generator, and feeds the score display.

Parameters:
- N, 10: number of mole channels (1..16).
- KEYCODES, {9'h016,9'h01E,9'h026,9'h025,9'h02E,9'h036,9'h03D,9'h03E,9'h046,9'h045}: N×9-bit flattened keycode table; channel i uses bits [9*i+:9], so channel 9 = key "1" and channel 0 = key "0". Codes are distinct.
- CW, 8: width of all counters and streaks.

Ports:
- clk  in  1  system clock
- rst  in  1  asynchronous, active-low reset
- clear  in  1  synchronous clear of counters, streaks and channel FSMs
- mole_on  in  N  mole lit per channel
- last_change  in  9  most recent keycode from the keyboard decoder
- key_down  in  512  key-held vector from the keyboard decoder
- hit_pulse  out  1  one-cycle pulse per hit
- hit_vec  out  N  one-hot channel of the current hit; valid with hit_pulse
- miss_pulse  out  1  one-cycle pulse: mapped key pressed on a channel that is not UP
- escape_pulse  out  1  one-cycle pulse: at least one mole went dark unhit
- hit_count  out  CW  saturating hit counter
- miss_count  out  CW  saturating miss counter
- escape_count  out  CW  saturating escape counter
- streak  out  CW  consecutive hits since the last miss or escape
- best_streak  out  CW  maximum streak since reset/clear

Behaviour:
- Reset (rst=0, async): all outputs 0, all channels IDLE, press tracker cleared.
- Press event (evt):
  - Registers prev_code and prev_held = key_down[prev_code].
  - evt=1 when key_down[last_change]=1 AND (prev_held=0 OR prev_code≠last_change).
  - Holding a key yields exactly one evt.
  - At most one evt per cycle.
- Key match: channel k is the channel whose KEYCODES entry equals last_change. Unmapped codes produce no hit and no miss.
- Per-channel FSM:
  - IDLE→UP when mole_on=1.
  - UP→WHACKED on evt with match k and mole_on=1 in the same cycle → hit.
  - UP→IDLE when mole_on=0 → escape.
  - WHACKED→IDLE when mole_on=0; no escape.
  - evt matching a channel in IDLE or WHACKED → miss, including a second press on a lit mole.
  - Hit and mole_on falling in the same cycle: mole_on=0 wins → escape, and the evt is a miss.
- Latency: all pulses and counter updates are registered and appear in cycle T+1 after evt or the mole_on edge at T.
- hit_vec: 0 unless hit_pulse=1.
- Counters saturate at 2^CW−1; no wrap.
- Streak update, in order within a cycle:
  - Increment on hit.
  - Force to 0 if miss or escape occurred that cycle, so hit plus escape on another channel gives 0.
  - best_streak ← max(best_streak, new streak).
  - streak saturates.
- Multiple escapes in one cycle: escape_count += popcount, saturating; one escape_pulse.
- clear=1: same effect as reset on the next edge. Any evt in that cycle is dropped; the press tracker still updates.
- Reset mid-game: all channels go IDLE. A mole still lit re-arms to UP the cycle after release.

Decomposition:
- Shared package/header: channel state encodings (IDLE=2'd0, UP=2'd1, WHACKED=2'd2), default KEYCODES table, CW default.
- One sub-module, mole_chan_fsm: per-channel FSM with inputs mole_on, evt, match; outputs hit, miss, escape. Instantiated N times via generate.
- Press tracker, counters and streak logic stay in the top level.

Test Plan:
- mole_on[9]=1; pulse key 9'h016 held 5 cycles → one hit_pulse, hit_vec=10'h200, hit_count=1, streak=1.
- Same lit mole, release and repress 9'h016 → miss_pulse, miss_count=1, streak=0, best_streak=1.
- mole_on[3] 1→0 with no press → escape_pulse, escape_count=1; mole_on[3] and mole_on[4] fall together → escape_count=3.
- Press 9'h045 on mole_on[0] in the same cycle mole_on[0] falls → no hit; escape_count+1, miss_count+1.
- CW=4, 20 consecutive distinct hits → hit_count=15, streak=15, best_streak=15; unmapped code 9'h01C pressed → no pulse.
- Assert rst low mid-streak (streak=5) → all outputs 0 asynchronously; clear=1 with evt → evt ignored, counters 0.
